sinerom_reader: RTL

- Initiator side of the dual-port sine ROM interface.
- Phase accumulator drives two ROM read addresses: a primary address and a second address offset by a programmable phase.
- Absorbs the ROM's 1-cycle registered read latency.
- Presents paired samples downstream on a valid/ready handshake without losing or duplicating samples under backpressure.

---
 rtl/sinerom_reader_pkg.sv | 10 +
 rtl/sinerom_reader_phase_accum.sv | 26 ++
 rtl/sinerom_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sinerom_reader_pkg.sv
// Shared types for the sine ROM reader: controller state encoding.
package sinerom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sinerom_reader_phase_accum.sv
// Phase accumulator: advances by i_incr on each strobe; the top ADDRESS_WIDTH
// bits form the ROM sample index, the low bits carry fractional phase.
module phase_accum #(
  parameter int unsigned ACC_WIDTH     = 16,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_advance,
  input  logic [ACC_WIDTH-1:0]     i_incr,
  output logic [ADDRESS_WIDTH-1:0] o_index
);

  logic [ACC_WIDTH-1:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_advance) begin
      r_acc <= r_acc + i_incr;
    end
  end

  assign o_index = r_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];

endmodule

// File: rtl/sinerom_reader.sv
// Dual-address sine ROM reader with valid/ready output and 1-cycle ROM latency.
// Optional macro SINEROM_READER_SIGNED_OUT_EN: invert sample MSB at capture.
module sinerom_reader
  import sinerom_reader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ACC_WIDTH-1:0]     incr,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic [ADDRESS_WIDTH-1:0] rom_addr1,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  input  logic [DATA_WIDTH-1:0]    rom_dout1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [DATA_WIDTH-1:0]    dout1
);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_issued_addr;
  logic [ADDRESS_WIDTH-1:0] r_issued_addr1;
  logic                     r_inflight;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_dout;
  logic [DATA_WIDTH-1:0]    r_dout1;

  logic                     w_stall;
  logic                     w_issue;
  logic                     w_capture;
  logic [ADDRESS_WIDTH-1:0] w_index;
  logic [ADDRESS_WIDTH-1:0] w_index1;
  logic [DATA_WIDTH-1:0]    w_sample;
  logic [DATA_WIDTH-1:0]    w_sample1;

  assign w_stall   = r_out_valid & ~out_ready;
  assign w_issue   = (r_state == RUN) & ~w_stall;
  assign w_capture = r_inflight & ~w_stall;
  assign w_index1  = w_index + offset;

  phase_accum #(
    .ACC_WIDTH     (ACC_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_phase_accum (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_advance (w_issue),
    .i_incr    (incr),
    .o_index   (w_index)
  );

  // Without an issue the ROM re-reads the in-flight address so its registered
  // output stays valid across a stall; out_ready reaches rom_addr combinationally.
  always_comb begin
    rom_addr  = r_issued_addr;
    rom_addr1 = r_issued_addr1;
    if (w_issue) begin
      rom_addr  = w_index;
      rom_addr1 = w_index1;
    end
  end

`ifdef SINEROM_READER_SIGNED_OUT_EN
  assign w_sample  = {~rom_dout[DATA_WIDTH-1],  rom_dout[DATA_WIDTH-2:0]};
  assign w_sample1 = {~rom_dout1[DATA_WIDTH-1], rom_dout1[DATA_WIDTH-2:0]};
`else
  assign w_sample  = rom_dout;
  assign w_sample1 = rom_dout1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_issued_addr  <= '0;
      r_issued_addr1 <= '0;
      r_inflight     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_dout         <= '0;
      r_dout1        <= '0;
    end else begin
      if (w_issue) begin
        r_issued_addr  <= w_index;
        r_issued_addr1 <= w_index1;
        r_inflight     <= 1'b1;
      end else if (w_capture) begin
        r_inflight <= 1'b0;
      end

      if (w_capture) begin
        r_dout      <= w_sample;
        r_dout1     <= w_sample1;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (en) r_state <= RUN;
        end
        RUN: begin
          if (!en) r_state <= DRAIN;
        end
        DRAIN: begin
          if (en) begin
            r_state <= RUN;
          end else if (!r_inflight && (!r_out_valid || out_ready)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign dout1     = r_dout1;

endmodule
